alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//   Registered 6-bit integer ALU with four operations: add with carry, subtract with borrow, 6x6 multiply, bitwise AND.
//   Inputs are sampled on each rising clock edge. The 12-bit result and the carry/borrow flag are presented one cycle later.
//   Leaf datapath block used by a small controller that drives operands and an operation select every cycle.
// PARAMETERS
//   WIDTH   6    operand width in bits; result width is 2*WIDTH
// PORTS
//   clk        in   1        single system clock, rising edge
//   rst_n      in   1        asynchronous, active-low reset
//   A          in   WIDTH    operand A, unsigned
//   B          in   WIDTH    operand B, unsigned
//   alu_sel    in   2        operation: 00 ADD, 01 SUB, 10 MUL, 11 AND
//   carry_in   in   1        carry-in for ADD; borrow-in for SUB; ignored for MUL and AND
//   result     out  2*WIDTH  registered result
//   carry_out  out  1        registered carry (ADD) or borrow (SUB); 0 for MUL and AND
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low.
//   - Reset: when rst_n=0, result=0 and carry_out=0 immediately, independent of clk. They hold 0 until the first rising edge after rst_n=1.
//   - Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N. New operation accepted every cycle. No handshake, no stall.
//   - ADD (00): s = A + B + carry_in, computed at WIDTH+1 bits.
//       result[WIDTH-1:0] = s[WIDTH-1:0]; result[2W-1:WIDTH] = 0; carry_out = s[WIDTH].
//       Wrap case: 63+1+1 gives result=1, carry_out=1.
//   - SUB (01): d = A - B - carry_in, computed at WIDTH+1 bits in two's complement.
//       result[WIDTH-1:0] = d mod 2^WIDTH; upper bits 0.
//       carry_out = borrow = 1 iff A < B + carry_in (unsigned).
//       Underflow: 2-4 gives result=62, carry_out=1. Exact zero: 4-3-1 gives result=0, carry_out=0.
//   - MUL (10): result = A * B, full unsigned 2*WIDTH-bit product; carry_out = 0. Cannot overflow (63*63 = 3969).
//   - AND (11): result[WIDTH-1:0] = A & B; upper bits 0; carry_out = 0.
//   - carry_in never affects MUL or AND.
//   - Operation switching: no state is carried between cycles. The output depends only on the previous edge's inputs.
//   - Reset asserted mid-stream: outputs clear asynchronously. The operation in flight is discarded.
//   - X/Z on alu_sel is not defined. A verification assertion flags it when rst_n=1.
// STRUCTURE
//   - alu_pkg holds:
//       ALU_W = 6
//       typedef alu_op_e {OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_AND=2'b11}
//   - Sub-module alu_core: purely combinational.
//       Computes next_result and next_carry from A, B, alu_sel and carry_in.
//       Uses one (WIDTH+1)-bit adder/subtractor (B inverted, carry injected for SUB), a WIDTH x WIDTH multiplier and an AND array, selected by a case on alu_sel.
//   - Top level alu: instantiates alu_core and adds the output register stage with async active-low clear.
// TESTING
//   1. Reset: rst_n=0 with non-zero inputs -> result=0, carry_out=0 without a clock edge. Release rst_n; next edge loads the operation.
//   2. ADD: A=5, B=3, cin=0 -> 8, cout=0. A=63, B=1, cin=1 -> result=1, cout=1.
//   3. SUB: A=10, B=6, cin=0 -> 4, cout=0. A=4, B=3, cin=1 -> 0, cout=0. A=2, B=4, cin=0 -> 62 (12'b000000111110), cout=1.
//   4. MUL: A=10, B=15 -> 150, cout=0. A=63, B=63 -> 3969 (12'b111110000001). cin=1 must not change either product.
//   5. AND: 110011 & 101010 -> 100010. 111111 & 000000 -> 0. 111111 & 111111 -> 111111. Upper 6 bits always 0, cout=0.
//   6. Back-to-back ops on consecutive cycles, with rst_n pulsed mid-stream -> each result appears exactly 1 cycle later; the pulse clears outputs at once.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the registered 6-bit ALU: operand width and operation encoding.
package alu_pkg;

  localparam int ALU_W = 6;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_AND = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the controller (master) and the ALU (slave).
interface alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
);

  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [1:0]         alu_sel;
  logic               carry_in;
  logic [2*WIDTH-1:0] result;
  logic               carry_out;

  modport master (
    output A,
    output B,
    output alu_sel,
    output carry_in,
    input  result,
    input  carry_out
  );

  modport slave (
    input  A,
    input  B,
    input  alu_sel,
    input  carry_in,
    output result,
    output carry_out
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: shared add/subtract, full multiplier and AND array,
// selected by the operation code.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  alu_op_e            op_i,
  input  logic               carry_in_i,
  output logic [2*WIDTH-1:0] next_result_o,
  output logic               next_carry_o
);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH:0]   addsub;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0] and_v;

  // A - B - bin == A + ~B + ~bin; the adder's carry-out is then the inverse of the borrow.
  assign is_sub  = (op_i == OP_SUB);
  assign b_eff   = is_sub ? ~b_i : b_i;
  assign cin_eff = is_sub ? ~carry_in_i : carry_in_i;
  assign addsub  = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};

  assign product = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
  assign and_v   = a_i & b_i;

  // NOTE: every output gets a default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    next_result_o = '0;
    next_carry_o  = 1'b0;
    case (op_i)
      OP_ADD: begin
        next_result_o[WIDTH-1:0] = addsub[WIDTH-1:0];
        next_carry_o             = addsub[WIDTH];
      end
      OP_SUB: begin
        next_result_o[WIDTH-1:0] = addsub[WIDTH-1:0];
        next_carry_o             = ~addsub[WIDTH];
      end
      OP_MUL: next_result_o = product;
      OP_AND: next_result_o[WIDTH-1:0] = and_v;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered ALU top: combinational core followed by one output register stage
// with asynchronous active-low clear.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);

  logic [2*WIDTH-1:0] result_d;
  logic [2*WIDTH-1:0] result_q;
  logic               carry_d;
  logic               carry_q;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i           (bus.A),
    .b_i           (bus.B),
    .op_i          (alu_op_e'(bus.alu_sel)),
    .carry_in_i    (bus.carry_in),
    .next_result_o (result_d),
    .next_carry_o  (carry_d)
  );

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;

  // An unknown operation select has no defined result.
  a_sel_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(bus.alu_sel));

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_alu;
  import alu_pkg::*;

  localparam int W  = ALU_W;
  localparam int RW = 2 * W;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    sel;
    logic          cin;
    logic [RW-1:0] res;
    logic          cout;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  alu_if #(.WIDTH(W)) bus ();

  alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [RW:0] act, input logic [RW:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got result=%0d cout=%b, expected result=%0d cout=%b",
                  name, act[RW-1:0], act[RW], exp[RW-1:0], exp[RW]);
  endtask

  // Reference arithmetic from the operation definitions, returned as {carry, result}.
  function automatic logic [RW:0] model(input int a, input int b, input int op, input int cin);
    int            s;
    logic [RW-1:0] r;
    logic          c;
    r = '0;
    c = 1'b0;
    case (op)
      0: begin
        s = a + b + cin;
        r = RW'(s % (2 ** W));
        c = (s >= 2 ** W);
      end
      1: begin
        s = a - b - cin;
        c = (a < b + cin);
        if (s < 0) s += 2 ** W;
        r = RW'(s);
      end
      2: r = RW'(a * b);
      default: r = RW'(a & b);
    endcase
    return {c, r};
  endfunction

  logic [RW:0] exp_q = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q <= '0;
    else        exp_q <= model(int'(bus.A), int'(bus.B), int'(bus.alu_sel), int'(bus.carry_in));
  end

  always @(negedge clk) check("cycle_model", {bus.carry_out, bus.result}, exp_q);

  vec_t vecs [14];

  task automatic drive(input vec_t v);
    bus.A        = v.a;
    bus.B        = v.b;
    bus.alu_sel  = v.sel;
    bus.carry_in = v.cin;
  endtask

  initial begin
    vecs[0]  = '{6'd5,       6'd3,       2'b00, 1'b0, 12'd8,    1'b0};
    vecs[1]  = '{6'd63,      6'd1,       2'b00, 1'b1, 12'd1,    1'b1};
    vecs[2]  = '{6'd63,      6'd63,      2'b00, 1'b1, 12'd63,   1'b1};
    vecs[3]  = '{6'd10,      6'd6,       2'b01, 1'b0, 12'd4,    1'b0};
    vecs[4]  = '{6'd4,       6'd3,       2'b01, 1'b1, 12'd0,    1'b0};
    vecs[5]  = '{6'd2,       6'd4,       2'b01, 1'b0, 12'd62,   1'b1};
    vecs[6]  = '{6'd10,      6'd15,      2'b10, 1'b0, 12'd150,  1'b0};
    vecs[7]  = '{6'd10,      6'd15,      2'b10, 1'b1, 12'd150,  1'b0};
    vecs[8]  = '{6'd63,      6'd63,      2'b10, 1'b0, 12'd3969, 1'b0};
    vecs[9]  = '{6'd63,      6'd63,      2'b10, 1'b1, 12'd3969, 1'b0};
    vecs[10] = '{6'b110011,  6'b101010,  2'b11, 1'b1, 12'd34,   1'b0};
    vecs[11] = '{6'b111111,  6'b000000,  2'b11, 1'b0, 12'd0,    1'b0};
    vecs[12] = '{6'b111111,  6'b111111,  2'b11, 1'b1, 12'd63,   1'b0};
    vecs[13] = '{6'd0,       6'd1,       2'b01, 1'b0, 12'd63,   1'b1};

    rst_n = 1'b0;
    drive(vecs[0]);

    check("pin_add_wrap",  model(63, 1, 0, 1), {1'b1, 12'd1});
    check("pin_sub_under", model(2, 4, 1, 0),  {1'b1, 12'd62});
    check("pin_sub_zero",  model(4, 3, 1, 1),  {1'b0, 12'd0});
    check("pin_mul_max",   model(63, 63, 2, 1), {1'b0, 12'd3969});

    #3  check("reset_async", {bus.carry_out, bus.result}, '0);
    #9  rst_n = 1'b1;
    #1  check("reset_hold", {bus.carry_out, bus.result}, '0);
    @(posedge clk) #1 check("first_load", {bus.carry_out, bus.result}, {1'b0, 12'd8});

    // One vector at a time, each held for two edges.
    for (int i = 0; i < 14; i++) begin
      @(posedge clk) #2 drive(vecs[i]);
      @(posedge clk) #1 check($sformatf("vec%0d", i), {bus.carry_out, bus.result},
                              {vecs[i].cout, vecs[i].res});
    end

    // Back-to-back: a new vector every cycle, with a reset pulse mid-stream.
    @(posedge clk) #2 drive(vecs[0]);
    for (int i = 1; i < 14; i++) begin
      @(posedge clk) #1 check($sformatf("b2b%0d", i - 1), {bus.carry_out, bus.result},
                              {vecs[i-1].cout, vecs[i-1].res});
      #1 drive(vecs[i]);
      if (i == 7) begin
        #1 rst_n = 1'b0;
        #1 check("pulse_clear", {bus.carry_out, bus.result}, '0);
        rst_n = 1'b1;
      end
    end
    @(posedge clk) #1 check("b2b13", {bus.carry_out, bus.result}, {vecs[13].cout, vecs[13].res});

    @(posedge clk);
    #1 $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
